cnn16_mem_ctrl: RTL and testbench
=================================

// Module: cnn16_mem_ctrl
// PURPOSE
//  Word memory plus its access controller for the CNN-16 core. It sits directly below
//  the control unit and datapath: it consumes address/to_memory/write_en-style requests
//  and produces from_memory data and the mem_ready handshake that the control unit waits on.
//  It models a memory with programmable wait states. A back-door loader preloads programs.
// PARAMETERS
//  DEPTH        4096  number of 16-bit words implemented (addresses >= DEPTH are out of range)
//  WAIT_STATES  2     extra cycles inserted between request sampling and the array access (0..15)
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  rd_req    in   1   read request, level; sampled only in IDLE
//  wr_req    in   1   write request, level; sampled only in IDLE
//  address   in   12  word address, sampled with request
//  to_memory in   16  write data, sampled with request
//  from_mem  out  16  read data; updated only on read completion, held otherwise
//  mem_ready out  1   one-cycle completion pulse for every accepted request
//  busy      out  1   high from cycle after sampling until DONE state exits
//  addr_err  out  1   high together with mem_ready when captured address >= DEPTH
//  ld_en     in   1   back-door load strobe (bench/boot)
//  ld_addr   in   12  back-door load address
//  ld_data   in   16  back-door load data
// BEHAVIOUR
//  Reset: state=IDLE; mem_ready=0; busy=0; addr_err=0; from_mem=16'h0000; wait counter=0.
//   Array contents are NOT cleared by reset.
//  FSM: IDLE -> WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES=0) on sampled request;
//   WAIT counts WAIT_STATES cycles -> ACCESS; ACCESS -> DONE; DONE -> IDLE.
//  Timing: request sampled at edge E (op, address, to_memory latched). Array read/write
//   happens at edge E+WAIT_STATES+1. mem_ready, addr_err, and from_mem (reads) are registered
//   at that edge. mem_ready is high for exactly one cycle, until edge E+WAIT_STATES+2.
//  busy=1 from edge E until the DONE->IDLE edge.
//  rd_req and wr_req both high in IDLE: treated as a write; the read is dropped.
//  Requests are level-sensitive. A request still high in the IDLE cycle after DONE starts a
//   new transaction (one idle cycle between back-to-back accesses). The requester drops its
//   request in the mem_ready cycle.
//  Inputs changing during WAIT/ACCESS have no effect; the latched copies are used.
//  Out of range (address >= DEPTH): the transaction completes with normal timing.
//   - Write: the array is unchanged.
//   - Read: from_mem=16'h0000.
//   - addr_err pulses with mem_ready.
//  Back door: ld_en writes ld_data to array[ld_addr] only while in IDLE. In IDLE it takes
//   priority over a request in the same cycle; the request is not sampled and stays pending.
//   ld_en outside IDLE, or with ld_addr >= DEPTH, is ignored.
//  Reset mid-transaction: returns to IDLE immediately. A pending write is discarded (the array
//   is not written). No mem_ready is produced for the aborted request.
// TESTING
//  1 Assert rst_n=0 -> mem_ready=0, busy=0, addr_err=0, from_mem=0000 with no clock edge.
//  2 WAIT_STATES=2: wr 0x001<=A5A5 sampled at edge 10 -> mem_ready high only between edges
//    13 and 14; then rd 0x001 -> from_mem=A5A5 with mem_ready.
//  3 rd_req=wr_req=1, addr 0x002, data 5678 -> write done; later read of 0x002 = 5678.
//  4 DEPTH=16: rd 0x010 -> mem_ready=1, addr_err=1, from_mem=0000; wr 0x020<=FFFF -> no
//    array change.
//  5 ld 0x003<=1111; start wr 0x003<=2222; pulse rst_n low during WAIT -> no mem_ready;
//    read 0x003 = 1111.
//  6 rd_req held through two accesses -> two mem_ready pulses one IDLE cycle apart;
//    ld_en during busy -> ignored (target word unchanged).

Source files
------------

// File: rtl/cnn16_mem_ctrl.sv
// CNN-16 word memory with access controller: programmable wait states,
// one-cycle mem_ready completion pulse, out-of-range flagging and a back-door loader.
module cnn16_mem_ctrl #(
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [11:0] address,
    input  logic [15:0] to_memory,
    output logic [15:0] from_mem,
    output logic        mem_ready,
    output logic        busy,
    output logic        addr_err,
    input  logic        ld_en,
    input  logic [11:0] ld_addr,
    input  logic [15:0] ld_data
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic        op_wr;
    logic        op_oor;
    logic [11:0] op_addr;
    logic [15:0] op_data;
    logic        ld_ok;
    logic        req_take;

    logic [15:0] mem [DEPTH];

    function automatic logic in_range(input logic [11:0] a);
        return ({1'b0, a} < 13'(DEPTH));
    endfunction

    // A valid back-door load in IDLE wins; the request stays pending for the next cycle.
    assign ld_ok    = (state == S_IDLE) && ld_en && in_range(ld_addr);
    assign req_take = (state == S_IDLE) && !ld_ok && (rd_req || wr_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_take) begin
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (wait_cnt == WS_LAST) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Completion outputs are decoded from registered state and the latched range flag.
    always_comb begin
        mem_ready = (state == S_DONE);
        busy      = (state != S_IDLE);
        addr_err  = (state == S_DONE) && op_oor;
    end

    // Both-high requests latch as a write, dropping the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            op_wr    <= 1'b0;
            op_oor   <= 1'b0;
            op_addr  <= '0;
            op_data  <= '0;
            from_mem <= '0;
        end else begin
            if (req_take) begin
                op_wr    <= wr_req;
                op_addr  <= address;
                op_data  <= to_memory;
                op_oor   <= !in_range(address);
                wait_cnt <= '0;
            end
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (state == S_ACCESS && !op_wr) begin
                from_mem <= op_oor ? 16'h0000 : mem[op_addr[AW-1:0]];
            end
        end
    end

    // Array is never cleared; reset forces IDLE so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (ld_ok) begin
                mem[ld_addr[AW-1:0]] <= ld_data;
            end else if (state == S_ACCESS && op_wr && !op_oor) begin
                mem[op_addr[AW-1:0]] <= op_data;
            end
        end
    end

endmodule

// File: tb/tb_cnn16_mem_ctrl.sv
// Self-checking bench for cnn16_mem_ctrl: directed scenarios plus randomized
// transactions compared against an array-based reference of the memory and its timeline.
module tb_cnn16_mem_ctrl;

    localparam int DEPTH = 16;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [11:0] address = '0;
    logic [15:0] to_memory = '0;
    logic [15:0] from_mem;
    logic        mem_ready;
    logic        busy;
    logic        addr_err;
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [15:0] ld_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] model [DEPTH];
    logic [15:0] exp_rd = 16'h0000;

    cnn16_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .address   (address),
        .to_memory (to_memory),
        .from_mem  (from_mem),
        .mem_ready (mem_ready),
        .busy      (busy),
        .addr_err  (addr_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        if (a < DEPTH) model[a] = d;
        check("ld_busy_low", busy, 0);
    endtask

    // One transaction with the expected externally visible timeline:
    // sampled at edge E, mem_ready only between E+WS+1 and E+WS+2.
    task automatic xact(input bit wr, input bit rd, input logic [11:0] a, input logic [15:0] d,
                        input bit keep, input bit ld_busy, input bit ld_first);
        bit          oor;
        bit          is_wr;
        logic [11:0] la;
        logic [15:0] lv;
        oor   = (a >= DEPTH);
        is_wr = wr;
        @(negedge clk);
        wr_req = wr; rd_req = rd; address = a; to_memory = d;
        if (ld_first) begin
            la = 12'($urandom_range(0, DEPTH - 1));
            lv = 16'($urandom);
            ld_en = 1'b1; ld_addr = la; ld_data = lv;
            @(posedge clk); #1;
            model[la] = lv;
            check("ld_prio_busy", busy, 0);
            check("ld_prio_ready", mem_ready, 0);
            @(negedge clk);
            ld_en = 1'b0;
        end
        @(posedge clk); #1;
        check("start_busy", busy, 1);
        check("start_ready", mem_ready, 0);
        for (int k = 1; k <= WS; k++) begin
            @(negedge clk);
            if (k == 1) begin
                address = 12'($urandom); to_memory = 16'($urandom);
                if (ld_busy) begin
                    ld_en = 1'b1;
                    ld_addr = 12'($urandom_range(0, DEPTH - 1));
                    ld_data = 16'($urandom);
                end
            end else begin
                ld_en = 1'b0;
            end
            @(posedge clk); #1;
            check("wait_busy", busy, 1);
            check("wait_ready", mem_ready, 0);
        end
        ld_en = 1'b0;
        @(posedge clk); #1;
        if (is_wr && !oor) model[a] = d;
        if (!is_wr) exp_rd = oor ? 16'h0000 : model[a];
        check("done_ready", mem_ready, 1);
        check("done_busy", busy, 1);
        check("done_err", addr_err, oor);
        check("done_data", from_mem, exp_rd);
        if (!keep) begin
            wr_req = 1'b0; rd_req = 1'b0;
        end
        @(posedge clk); #1;
        check("idle_ready", mem_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_err", addr_err, 0);
        check("idle_data", from_mem, exp_rd);
    endtask

    initial begin
        #1;
        check("rst_ready", mem_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", addr_err, 0);
        check("rst_data", from_mem, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) load(12'(i), 16'($urandom));

        // basic write then read
        xact(1, 0, 12'h001, 16'hA5A5, 0, 0, 0);
        xact(0, 1, 12'h001, 16'h0000, 0, 0, 0);
        check("rd_a5a5", from_mem, 16'hA5A5);

        // both requests high behave as a write
        xact(1, 1, 12'h002, 16'h5678, 0, 0, 0);
        xact(0, 1, 12'h002, 16'h0000, 0, 0, 0);
        check("rd_5678", from_mem, 16'h5678);

        // out of range read and write
        xact(0, 1, 12'h010, 16'h0000, 0, 0, 0);
        xact(1, 0, 12'h020, 16'hFFFF, 0, 0, 0);
        xact(1, 0, 12'h00F, 16'h0F0F, 0, 0, 0);
        xact(0, 1, 12'hFFF, 16'h0000, 0, 0, 0);

        // reset during WAIT aborts the write
        load(12'h003, 16'h1111);
        @(negedge clk);
        wr_req = 1'b1; address = 12'h003; to_memory = 16'h2222;
        @(posedge clk); #1;
        check("abort_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", mem_ready, 0);
        check("abort_busy_low", busy, 0);
        check("abort_err", addr_err, 0);
        check("abort_data", from_mem, 16'h0000);
        exp_rd = 16'h0000;
        wr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_no_ready", mem_ready, 0);
        end
        xact(0, 1, 12'h003, 16'h0000, 0, 0, 0);
        check("rd_1111", from_mem, 16'h1111);

        // held read gives two pulses one idle cycle apart; load during busy ignored
        xact(0, 1, 12'h005, 16'h0000, 1, 1, 0);
        xact(0, 1, 12'h005, 16'h0000, 0, 1, 0);

        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            xact(kind != 0, kind != 1, 12'($urandom_range(0, 31)), 16'($urandom), 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
        end

        for (int i = 0; i < DEPTH; i++) xact(0, 1, 12'(i), 16'h0000, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
